// File: rtl/count_binary_pio_ext.sv
// count_binary_pio_ext: Avalon-MM bidirectional PIO; COUNT_BINARY_PIO_IRQ_EN enables edge capture, priming FSM and irq
module count_binary_pio_ext #(
  parameter int          DATA_WIDTH  = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int          EDGE_TYPE   = 0,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] oe,
  output logic                  irq
);
  localparam logic [2:0] A_DATA = 3'd0;
  localparam logic [2:0] A_DIR  = 3'd1;
  localparam logic [2:0] A_MASK = 3'd2;
  localparam logic [2:0] A_EDGE = 3'd3;
  localparam logic [2:0] A_SET  = 3'd4;
  localparam logic [2:0] A_CLR  = 3'd5;
  logic                  wr;
  logic                  unused_wd;
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] in_sync;
  logic [DATA_WIDTH-1:0] edgecap;
  logic [DATA_WIDTH-1:0] irq_mask;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[DATA_WIDTH-1:0];
  assign unused_wd = ^writedata;
  assign in_sync   = sync_q[SYNC_STAGES-1];
  always_ff @(posedge clk)
    if (reset) sync_q <= '{default: '0};
    else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  always_ff @(posedge clk)
    if (reset) begin
      out_port <= RESET_VALUE[DATA_WIDTH-1:0];
      oe       <= '0;
    end else if (wr) begin
      out_port <= address == A_DATA ? wd :
                  address == A_SET  ? out_port | wd :
                  address == A_CLR  ? out_port & ~wd : out_port;
      oe       <= address == A_DIR ? wd : oe;
    end
  always_comb
    rd_mux = address == A_DATA ? (oe & out_port) | (~oe & in_sync) :
             address == A_DIR  ? oe :
             address == A_MASK ? irq_mask :
             address == A_EDGE ? edgecap : '0;
  always_ff @(posedge clk)
    if (reset) readdata <= '0;
    else if (chipselect) readdata <= 32'(rd_mux);
`ifdef COUNT_BINARY_PIO_IRQ_EN
  typedef enum logic {PRIME, RUN} state_t;
  state_t                state, state_n;
  logic [2:0]            prime_cnt;
  logic [DATA_WIDTH-1:0] in_prev, rise, fall, edge_hit;
  always_ff @(posedge clk) begin
    state     <= reset ? PRIME : state_n;
    prime_cnt <= reset ? 3'(SYNC_STAGES + 1) :
                 state == PRIME && prime_cnt != 3'd0 ? prime_cnt - 3'd1 : prime_cnt;
    in_prev   <= reset ? '0 : in_sync;
  end
  always_comb begin
    state_n  = state == PRIME && prime_cnt == 3'd0 ? RUN : state;
    rise     = in_sync & ~in_prev;
    fall     = ~in_sync & in_prev;
    edge_hit = state != RUN ? '0 : EDGE_TYPE == 0 ? rise : EDGE_TYPE == 1 ? fall : rise | fall;
  end
  always_ff @(posedge clk)
    if (reset) begin
      irq_mask <= '0;
      edgecap  <= '0;
      irq      <= 1'b0;
    end else begin
      irq_mask <= wr && address == A_MASK ? wd : irq_mask;
      edgecap  <= (edgecap & ~(wr && address == A_EDGE ? wd : '0)) | edge_hit;
      irq      <= |(edgecap & irq_mask);
    end
`else
  assign irq_mask = '0;
  assign edgecap  = '0;
  assign irq      = 1'b0;
`endif
endmodule
